// File: rtl/ascon_pack.sv
// Shared types for the Ascon wrapper and its host-side DMA sequencer.
package ascon_pack;

  typedef logic [63:0]  u64_t;
  typedef logic [127:0] u128_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/ascon_dma.sv
// Host-side job sequencer for the Ascon AEAD wrapper: starts the core, feeds
// AD then PT words from SRAM into the wrapper FIFOs, drains CT back to SRAM
// and captures the tag.
module ascon_dma
  import ascon_pack::*;
#(
  parameter int DataAddrWidth = 7,
  parameter int MemAddrWidth  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     go_i,
  input  logic [MemAddrWidth-1:0]  ad_base_i,
  input  logic [MemAddrWidth-1:0]  pt_base_i,
  input  logic [MemAddrWidth-1:0]  ct_base_i,
  input  logic [DataAddrWidth-1:0] ad_words_i,
  input  logic [DataAddrWidth-1:0] pt_words_i,
  output logic                     busy_o,
  output logic                     done_o,
  output u128_t                    tag_o,
  output logic                     mem_rd_en_o,
  output logic [MemAddrWidth-1:0]  mem_raddr_o,
  input  u64_t                     mem_rdata_i,
  output logic                     mem_wr_en_o,
  output logic [MemAddrWidth-1:0]  mem_waddr_o,
  output u64_t                     mem_wdata_o,
  output logic                     start_o,
  input  logic                     ready_i,
  input  logic                     tag_valid_i,
  input  u128_t                    tag_i,
  output logic                     ad_push_o,
  output u64_t                     ad_o,
  input  logic                     ad_full_i,
  output logic                     pt_push_o,
  output u64_t                     pt_o,
  input  logic                     pt_full_i,
  output logic                     ct_pop_o,
  input  u64_t                     ct_i,
  input  logic                     ct_empty_i
);

  // Word address = base + index, wrapping modulo the SRAM size.
  function automatic logic [MemAddrWidth-1:0] f_addr(input logic [MemAddrWidth-1:0]  base,
                                                     input logic [DataAddrWidth-1:0] idx);
    return base + MemAddrWidth'(idx);
  endfunction

  dma_state_e                r_state, w_state_nxt;
  logic [MemAddrWidth-1:0]   r_ad_base, r_pt_base, r_ct_base;
  logic [DataAddrWidth-1:0]  r_ad_words, r_pt_words;
  logic [DataAddrWidth-1:0]  r_ad_cnt, r_pt_cnt, r_ct_cnt;
  logic                      r_rd_pend, r_rd_pt, r_tag_seen;
  logic                      r_wr_en;
  logic [MemAddrWidth-1:0]   r_waddr;
  u64_t                      r_wdata;
  u128_t                     r_tag;

  logic                      w_go, w_run, w_ad_left, w_pt_left, w_sel_pt;
  logic                      w_tgt_full, w_issue, w_pop, w_exit;
  logic [MemAddrWidth-1:0]   w_raddr;

  assign w_go       = (r_state == IDLE) & go_i;
  assign w_run      = (r_state == RUN);
  assign w_ad_left  = (r_ad_cnt != r_ad_words);
  assign w_pt_left  = (r_pt_cnt != r_pt_words);
  // AD is exhausted before any PT word is fetched, so AD->PT needs no bubble.
  assign w_sel_pt   = ~w_ad_left;
  assign w_tgt_full = w_sel_pt ? pt_full_i : ad_full_i;
  assign w_issue    = w_run & ~r_rd_pend & (w_ad_left | w_pt_left) & ~w_tgt_full;
  assign w_raddr    = w_sel_pt ? f_addr(r_pt_base, r_pt_cnt) : f_addr(r_ad_base, r_ad_cnt);
  assign w_pop      = w_run & ~ct_empty_i & (r_ct_cnt < r_pt_words);
  // Feeder idle with nothing in flight, all CT popped and tag captured.
  assign w_exit     = ~w_ad_left & ~w_pt_left & ~r_rd_pend &
                      (r_ct_cnt == r_pt_words) & r_tag_seen;

  assign mem_rd_en_o = w_issue;
  assign mem_raddr_o = w_issue ? w_raddr : '0;
  assign ad_push_o   = r_rd_pend & ~r_rd_pt;
  assign pt_push_o   = r_rd_pend & r_rd_pt;
  assign ad_o        = ad_push_o ? mem_rdata_i : '0;
  assign pt_o        = pt_push_o ? mem_rdata_i : '0;
  assign ct_pop_o    = w_pop;
  assign mem_wr_en_o = r_wr_en;
  assign mem_waddr_o = r_waddr;
  assign mem_wdata_o = r_wdata;
  assign tag_o       = r_tag;

  // Job parameters captured when a job is accepted; they only matter while busy.
  always_ff @(posedge clk_i) begin
    if (w_go) begin
      r_ad_base  <= ad_base_i;
      r_pt_base  <= pt_base_i;
      r_ct_base  <= ct_base_i;
      r_ad_words <= ad_words_i;
      r_pt_words <= pt_words_i;
    end
  end

  // Job state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and per-state control outputs.
  always_comb begin
    w_state_nxt = r_state;
    start_o     = 1'b0;
    done_o      = 1'b0;
    busy_o      = (r_state != IDLE);
    case (r_state)
      IDLE:  if (go_i) w_state_nxt = START;
      START: if (ready_i) begin
               start_o     = 1'b1;
               w_state_nxt = RUN;
             end
      RUN:   if (w_exit) w_state_nxt = DONE;
      DONE:  begin
               done_o      = 1'b1;
               w_state_nxt = IDLE;
             end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Feeder: single outstanding SRAM read, pushed to its FIFO the cycle it returns.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_pend <= 1'b0;
      r_rd_pt   <= 1'b0;
      r_ad_cnt  <= '0;
      r_pt_cnt  <= '0;
    end else if (w_go) begin
      r_rd_pend <= 1'b0;
      r_ad_cnt  <= '0;
      r_pt_cnt  <= '0;
    end else begin
      r_rd_pend <= w_issue;
      if (w_issue) begin
        r_rd_pt <= w_sel_pt;
        if (w_sel_pt) r_pt_cnt <= r_pt_cnt + 1'b1;
        else          r_ad_cnt <= r_ad_cnt + 1'b1;
      end
    end
  end

  // Drainer: each popped CT word becomes an SRAM write on the following cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ct_cnt <= '0;
      r_wr_en  <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else if (w_go) begin
      r_ct_cnt <= '0;
      r_wr_en  <= 1'b0;
    end else begin
      r_wr_en <= w_pop;
      if (w_pop) begin
        r_waddr  <= f_addr(r_ct_base, r_ct_cnt);
        r_wdata  <= ct_i;
        r_ct_cnt <= r_ct_cnt + 1'b1;
      end
    end
  end

  // Tag capture while the core is active; held until the next job's capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tag      <= '0;
      r_tag_seen <= 1'b0;
    end else if (w_go) begin
      r_tag_seen <= 1'b0;
    end else if (tag_valid_i && (r_state == START || r_state == RUN)) begin
      r_tag      <= tag_i;
      r_tag_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ascon_dma.sv
// Self-checking bench for ascon_dma with SRAM, FIFO and core stubs.
module tb_ascon_dma;

  localparam logic [63:0] K = 64'h5A5A_0F0F_C3C3_9696;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         go_i = 1'b0;
  logic [7:0]   ad_base_i = '0, pt_base_i = '0, ct_base_i = '0;
  logic [6:0]   ad_words_i = '0, pt_words_i = '0;
  logic         busy_o, done_o, start_o;
  logic [127:0] tag_o;
  logic         mem_rd_en_o, mem_wr_en_o;
  logic [7:0]   mem_raddr_o, mem_waddr_o;
  logic [63:0]  mem_rdata_i = '0, mem_wdata_o;
  logic         ready_i = 1'b1, tag_valid_i = 1'b0;
  logic [127:0] tag_i = '0;
  logic         ad_push_o, pt_push_o, ct_pop_o;
  logic [63:0]  ad_o, pt_o, ct_i;
  logic         ad_full_i = 1'b0, pt_full_i = 1'b0, ct_empty_i;
  logic         ct_stall = 1'b0;

  ascon_dma #(.DataAddrWidth(7), .MemAddrWidth(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .go_i(go_i),
    .ad_base_i(ad_base_i), .pt_base_i(pt_base_i), .ct_base_i(ct_base_i),
    .ad_words_i(ad_words_i), .pt_words_i(pt_words_i),
    .busy_o(busy_o), .done_o(done_o), .tag_o(tag_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i),
    .mem_wr_en_o(mem_wr_en_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
    .start_o(start_o), .ready_i(ready_i), .tag_valid_i(tag_valid_i), .tag_i(tag_i),
    .ad_push_o(ad_push_o), .ad_o(ad_o), .ad_full_i(ad_full_i),
    .pt_push_o(pt_push_o), .pt_o(pt_o), .pt_full_i(pt_full_i),
    .ct_pop_o(ct_pop_o), .ct_i(ct_i), .ct_empty_i(ct_empty_i)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int n_start = 0, n_rd = 0, n_ad_push = 0, n_pt_push = 0, n_pop = 0, n_wr = 0, n_done = 0;
  int start_cyc = 0, done_cyc = 0, first_push_cyc = -1;
  int base_start, base_rd, base_ad, base_pt, base_pop, base_wr, base_done;
  int j_ad = 0, j_pt = 0, last_tag_cyc = -1;
  logic [127:0] exp_tag;
  logic [63:0]  exp_ad[$], exp_pt[$];
  logic [71:0]  exp_wr[$];

  logic [63:0] mem    [256];
  logic [63:0] ct_mem [256];
  logic [63:0] fifo   [256];
  int ct_wr = 0, ct_rd = 0;

  // SRAM stub: one-cycle read latency; CT writes land in a separate image.
  always @(posedge clk) begin
    if (mem_rd_en_o) mem_rdata_i <= mem[mem_raddr_o];
    if (mem_wr_en_o) ct_mem[mem_waddr_o] <= mem_wdata_o;
  end

  // Core stub: every PT word yields CT = PT ^ K in a first-word-fall-through FIFO.
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      ct_wr <= 0;
      ct_rd <= 0;
    end else begin
      if (pt_push_o) begin
        fifo[ct_wr[7:0]] <= pt_o ^ K;
        ct_wr <= ct_wr + 1;
      end
      if (ct_pop_o) ct_rd <= ct_rd + 1;
    end
  end
  assign ct_empty_i = (ct_wr == ct_rd) | ct_stall;
  assign ct_i       = fifo[ct_rd[7:0]];

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [63:0] e;
    logic [71:0] w;
    cyc++;
    if (!rst_i) begin
      if (start_o) begin
        n_start++; start_cyc = cyc; checks++;
        if (!ready_i) begin failures++; $display("FAIL start_without_ready start_o=%b ready_i=%b", start_o, ready_i); end
      end
      if (mem_rd_en_o) begin
        checks++;
        if (((n_rd - base_rd) < j_ad) ? ad_full_i : pt_full_i) begin
          failures++; $display("FAIL read_while_full addr=%h ad_full=%b pt_full=%b", mem_raddr_o, ad_full_i, pt_full_i);
        end
        n_rd++;
      end
      if (ad_push_o) begin
        checks++;
        if (exp_ad.size() == 0) begin failures++; $display("FAIL ad_push_extra got=%h expected none", ad_o); end
        else begin
          e = exp_ad.pop_front();
          if (ad_o !== e) begin failures++; $display("FAIL ad_data got=%h expected=%h", ad_o, e); end
        end
        n_ad_push++;
        if (first_push_cyc < 0) first_push_cyc = cyc;
      end
      if (pt_push_o) begin
        checks++;
        if (exp_pt.size() == 0) begin failures++; $display("FAIL pt_push_extra got=%h expected none", pt_o); end
        else begin
          e = exp_pt.pop_front();
          if (pt_o !== e) begin failures++; $display("FAIL pt_data got=%h expected=%h", pt_o, e); end
        end
        n_pt_push++;
        if (first_push_cyc < 0) first_push_cyc = cyc;
      end
      if (ct_pop_o) begin
        checks++; n_pop++;
        if (ct_empty_i) begin failures++; $display("FAIL pop_while_empty ct_pop_o=%b ct_empty_i=%b", ct_pop_o, ct_empty_i); end
      end
      if (mem_wr_en_o) begin
        checks++; n_wr++;
        if (exp_wr.size() == 0) begin failures++; $display("FAIL ct_write_extra addr=%h data=%h expected none", mem_waddr_o, mem_wdata_o); end
        else begin
          w = exp_wr.pop_front();
          if ({mem_waddr_o, mem_wdata_o} !== w)
            begin failures++; $display("FAIL ct_write got=%h/%h expected=%h/%h", mem_waddr_o, mem_wdata_o, w[71:64], w[63:0]); end
        end
      end
      if (done_o) begin n_done++; done_cyc = cyc; end
    end
  end

  task automatic setup_job(input int ad_n, input int pt_n, input logic [7:0] adb,
                           input logic [7:0] ptb, input logic [7:0] ctb);
    logic [7:0]  a;
    logic [63:0] v;
    exp_ad.delete(); exp_pt.delete(); exp_wr.delete();
    for (int i = 0; i < ad_n; i++) begin
      a = adb + 8'(i); v = {$urandom, $urandom}; mem[a] = v; exp_ad.push_back(v);
    end
    for (int i = 0; i < pt_n; i++) begin
      a = ptb + 8'(i); v = {$urandom, $urandom}; mem[a] = v; exp_pt.push_back(v);
      exp_wr.push_back({ctb + 8'(i), v ^ K});
    end
    exp_tag = {$urandom, $urandom, $urandom, $urandom};
    j_ad = ad_n; j_pt = pt_n;
    base_start = n_start; base_rd = n_rd; base_ad = n_ad_push; base_pt = n_pt_push;
    base_pop = n_pop; base_wr = n_wr; base_done = n_done; first_push_cyc = -1;
    ad_base_i = adb; pt_base_i = ptb; ct_base_i = ctb;
    ad_words_i = 7'(ad_n); pt_words_i = 7'(pt_n);
  endtask

  task automatic run_job(input int ad_n, input int pt_n, input logic [7:0] adb, input logic [7:0] ptb,
                         input logic [7:0] ctb, input int ready_dly, input int full_at, input int full_len,
                         input int stall_at, input int stall_len);
    int full_cnt = 0, stall_cnt = 0, burst = 0;
    bit tag_given = 0, done_seen = 0;
    logic [7:0] a;
    setup_job(ad_n, pt_n, adb, ptb, ctb);
    last_tag_cyc = -1;
    ready_i = (ready_dly == 0);
    @(posedge clk); #1 go_i = 1'b1;
    @(posedge clk); #1 go_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL busy_after_go got=%b expected=1", busy_o); end
    for (int it = 0; it < 3000 && !done_seen; it++) begin
      ready_i = (it >= ready_dly);
      if (tag_valid_i) tag_valid_i = 1'b0;
      else if (!tag_given && n_start > base_start &&
               (n_ad_push - base_ad + n_pt_push - base_pt) == ad_n + pt_n) begin
        tag_valid_i = 1'b1; tag_i = exp_tag; tag_given = 1; last_tag_cyc = cyc + 1;
      end
      pt_full_i = 1'b0;
      if (full_at >= 0 && (n_pt_push - base_pt) >= full_at && full_cnt < full_len) begin
        pt_full_i = 1'b1; full_cnt++;
      end
      if (stall_at >= 0 && stall_cnt < stall_len && (n_pt_push - base_pt) >= stall_at) begin
        ct_stall = 1'b1; stall_cnt++;
      end else if (ct_stall) begin
        ct_stall = 1'b0; burst = ct_wr - ct_rd;
      end
      #1;
      if (burst > 0) begin
        checks++; burst--;
        if (ct_pop_o !== 1'b1) begin failures++; $display("FAIL ct_resume_rate ct_pop_o=%b expected=1", ct_pop_o); end
      end
      @(posedge clk); #1;
      done_seen = (n_done > base_done);
    end
    tag_valid_i = 1'b0; pt_full_i = 1'b0; ct_stall = 1'b0; ready_i = 1'b1;
    checks++;
    if (!done_seen) begin failures++; $display("FAIL job_timeout done_count=%0d expected=1", n_done - base_done); end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (n_done - base_done != 1) begin failures++; $display("FAIL done_pulse count=%0d expected=1", n_done - base_done); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL busy_after_done got=%b expected=0", busy_o); end
    checks++;
    if (n_start - base_start != 1) begin failures++; $display("FAIL start_pulses got=%0d expected=1", n_start - base_start); end
    checks++;
    if ((n_ad_push - base_ad) != ad_n || (n_pt_push - base_pt) != pt_n)
      begin failures++; $display("FAIL push_count ad=%0d pt=%0d expected=%0d/%0d", n_ad_push - base_ad, n_pt_push - base_pt, ad_n, pt_n); end
    checks++;
    if ((n_pop - base_pop) != pt_n || (n_wr - base_wr) != pt_n || (n_rd - base_rd) != ad_n + pt_n)
      begin failures++; $display("FAIL pop_wr_rd_count pop=%0d wr=%0d rd=%0d expected=%0d/%0d/%0d",
                                  n_pop - base_pop, n_wr - base_wr, n_rd - base_rd, pt_n, pt_n, ad_n + pt_n); end
    checks++;
    if (tag_o !== exp_tag) begin failures++; $display("FAIL tag got=%h expected=%h", tag_o, exp_tag); end
    for (int i = 0; i < pt_n; i++) begin
      a = ctb + 8'(i);
      checks++;
      if (ct_mem[a] !== (mem[ptb + 8'(i)] ^ K))
        begin failures++; $display("FAIL ct_mem[%h] got=%h expected=%h", a, ct_mem[a], mem[ptb + 8'(i)] ^ K); end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({busy_o, done_o, start_o, mem_rd_en_o, mem_wr_en_o, ad_push_o, pt_push_o, ct_pop_o,
         mem_raddr_o, mem_waddr_o, mem_wdata_o, ad_o, pt_o} !== '0)
      begin failures++; $display("FAIL reset_outputs busy=%b wr=%b waddr=%h expected all 0", busy_o, mem_wr_en_o, mem_waddr_o); end
    checks++;
    if (tag_o !== '0) begin failures++; $display("FAIL reset_tag got=%h expected=0", tag_o); end
    rst_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({busy_o, start_o, mem_rd_en_o, mem_wr_en_o} !== 4'b0)
      begin failures++; $display("FAIL idle_after_reset busy=%b start=%b rd=%b wr=%b expected 0", busy_o, start_o, mem_rd_en_o, mem_wr_en_o); end
  endtask

  task automatic test_basic();
    run_job(2, 3, 8'h00, 8'h10, 8'h20, 3, -1, 0, -1, 0);
    checks++;
    if (first_push_cyc - start_cyc != 2)
      begin failures++; $display("FAIL first_push_latency got=%0d expected=2", first_push_cyc - start_cyc); end
  endtask

  task automatic test_zero_sizes();
    run_job(0, 0, 8'h30, 8'h38, 8'h3C, 0, -1, 0, -1, 0);
    checks++;
    if (done_cyc != last_tag_cyc + 2)
      begin failures++; $display("FAIL zero_done_latency got=%0d expected=%0d", done_cyc, last_tag_cyc + 2); end
  endtask

  task automatic test_addr_wrap();
    run_job(1, 4, 8'hFC, 8'h08, 8'hFE, 0, -1, 0, -1, 0);
  endtask

  task automatic test_backpressure();
    run_job(2, 6, 8'h80, 8'h90, 8'hA0, 0, 2, 20, -1, 0);
  endtask

  task automatic test_ct_stall();
    run_job(1, 5, 8'hB0, 8'hC0, 8'hD0, 0, -1, 0, 1, 10);
  endtask

  task automatic test_go_reset();
    int t;
    setup_job(3, 4, 8'h40, 8'h50, 8'h60);
    @(posedge clk); #1 go_i = 1'b1;
    @(posedge clk); #1 go_i = 1'b0;
    for (t = 0; t < 200 && (n_pt_push - base_pt) < 1; t++) @(posedge clk);
    checks++;
    if ((n_pt_push - base_pt) < 1) begin failures++; $display("FAIL go_reset_wait pt_pushes=%0d expected>=1", n_pt_push - base_pt); end
    #1;
    ad_base_i = 8'hE0; pt_base_i = 8'hE8; ct_base_i = 8'hF0; go_i = 1'b1;
    @(posedge clk); #1 go_i = 1'b0;
    repeat (4) @(posedge clk); #1;
    checks++;
    if (n_start - base_start != 1 || busy_o !== 1'b1)
      begin failures++; $display("FAIL go_ignored starts=%0d busy=%b expected=1/1", n_start - base_start, busy_o); end
    rst_i = 1'b1;
    #1;
    checks++;
    if ({busy_o, done_o, start_o, mem_rd_en_o, mem_wr_en_o, ad_push_o, pt_push_o, ct_pop_o,
         mem_raddr_o, mem_waddr_o, mem_wdata_o, ad_o, pt_o} !== '0)
      begin failures++; $display("FAIL midjob_reset_outputs busy=%b rd=%b wr=%b expected all 0", busy_o, mem_rd_en_o, mem_wr_en_o); end
    checks++;
    if (tag_o !== '0) begin failures++; $display("FAIL midjob_reset_tag got=%h expected=0", tag_o); end
    repeat (2) @(posedge clk); #1 rst_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL idle_after_midjob_reset busy=%b expected=0", busy_o); end
    run_job(2, 3, 8'h04, 8'h14, 8'h70, 0, -1, 0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_sizes();
    test_addr_wrap();
    test_backpressure();
    test_ct_stall();
    test_go_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
